// File: rtl/dmem_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with word-serial refill.
// Define DMEM_CACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module dmem_cache #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned LINES          = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack
`ifdef DMEM_CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int unsigned WB    = $clog2(WORDS_PER_LINE);
    localparam int unsigned IB    = $clog2(LINES);
    localparam int unsigned WBW   = (WB == 0) ? 1 : WB;
    localparam int unsigned DAW   = IB + WB;
    localparam int unsigned TW    = ADDR_WIDTH - 2 - IB - WB;
    localparam int unsigned DEPTH = LINES * WORDS_PER_LINE;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t           state;
    logic [WBW-1:0]   cnt;
    logic             done;
    logic             wr_hit;
    logic [IB-1:0]    rf_idx;
    logic [TW-1:0]    rf_tag;
    logic [LINES-1:0] valid;
    logic [TW-1:0]    tags [LINES];
    logic [31:0]      data [DEPTH];

    logic [DAW-1:0]   cpu_flat;
    logic [IB-1:0]    cpu_idx;
    logic [TW-1:0]    cpu_tag;
    logic             hit;

    // The {index, word} field is contiguous, so it directly addresses the data array.
    assign cpu_flat = DAW'(cpu_addr >> 2);
    assign cpu_idx  = IB'(cpu_addr >> (2 + WB));
    assign cpu_tag  = TW'(cpu_addr >> (2 + WB + IB));
    assign hit      = valid[cpu_idx] && (tags[cpu_idx] == cpu_tag);

    assign cpu_rdata = reset ? 32'd0 : data[cpu_flat];

    // Stall unless an idle load hits, or the store just finished (done cycle).
    always_comb begin
        cpu_stall = 1'b0;
        if (!reset && cpu_req) begin
            if (state == IDLE) cpu_stall = !done && (cpu_we || !hit);
            else               cpu_stall = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            done      <= 1'b0;
            wr_hit    <= 1'b0;
            rf_idx    <= '0;
            rf_tag    <= '0;
            valid     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (cpu_req && !done) begin
                        if (cpu_we) begin
                            state     <= WRITE;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_wdata <= cpu_wdata;
                            wr_hit    <= hit;
                        end else if (!hit) begin
                            state          <= REFILL;
                            cnt            <= '0;
                            mem_req        <= 1'b1;
                            mem_we         <= 1'b0;
                            mem_addr       <= (cpu_addr >> (2 + WB)) << (2 + WB);
                            rf_idx         <= cpu_idx;
                            rf_tag         <= cpu_tag;
                            valid[cpu_idx] <= 1'b0;
                        end
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        if (cnt == WBW'(WORDS_PER_LINE - 1)) begin
                            mem_req       <= 1'b0;
                            valid[rf_idx] <= 1'b1;
                            tags[rf_idx]  <= rf_tag;
                            state         <= IDLE;
                        end else begin
                            cnt      <= cnt + WBW'(1);
                            mem_addr <= mem_addr + ADDR_WIDTH'(4);
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data array is not reset; lines become usable only through their valid bit.
    always_ff @(posedge clk) begin
        if (!reset && mem_ack) begin
            if (state == REFILL)
                data[DAW'(mem_addr >> 2)] <= mem_rdata;
            else if (state == WRITE && wr_hit)
                data[DAW'(mem_addr >> 2)] <= mem_wdata;
        end
    end

`ifdef DMEM_CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && cpu_req && !cpu_we && !done) begin
            if (hit) begin
                if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end else if (miss_count != '1) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
